// File: rtl/control_sequencer.sv
// control_sequencer
// Fetch/decode/execute controller for the 4-bit Aeolus datapath. Issues the
// program counter, the register-file load strobes, the register-input source
// select and the ALU operation. Every instruction takes three cycles
// (FETCH, DECODE, EXECUTE) until a HLT parks the sequencer in HALT.
//
// Build option: define SEQ_SINGLE_STEP_EN to add the `step` input. FETCH
// then waits for step=1 at a rising edge before capturing the instruction.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   instr      in   ROM word at pc ([7:4] opcode, [3:0] immediate)
//   alu_carry  in   ALU carry/borrow out, valid during EXECUTE
//   step       in   single-step pulse (SEQ_SINGLE_STEP_EN only)
//   pc         out  ROM address
//   imm        out  immediate of the held instruction
//   src_sel    out  register-input source: 00 imm, 01 ALU, 10 A register
//   alu_sub    out  1 = A-B, 0 = A+B
//   LDA/LDB/LDO out single-cycle register-file load enables
//   halted     out  high while in HALT
module control_sequencer #(
  parameter int unsigned PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          instr,
  input  logic                alu_carry,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          imm,
  output logic [1:0]          src_sel,
  output logic                alu_sub,
  output logic                LDA,
  output logic                LDB,
  output logic                LDO,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDAI  = 4'h1,
    OP_LDBI  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_OUT   = 4'h5,
    OP_MOVBA = 4'h6,
    OP_JMP   = 4'h7,
    OP_JC    = 4'h8,
    OP_HLT   = 4'hF
  } op_e;

  state_e              state_q, state_d;
  logic [7:0]          ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          imm_q, imm_d;
  logic [1:0]          src_q, src_d;
  logic                sub_q, sub_d;
  logic                cflag_q, cflag_d;
  logic                lda_q, lda_d;
  logic                ldb_q, ldb_d;
  logic                ldo_q, ldo_d;
  logic                halted_q, halted_d;
  logic                fetch_go;
  op_e                 op;
  logic [PC_WIDTH-1:0] pc_inc, pc_imm;

  assign op     = op_e'(ir_q[7:4]);
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign pc_imm = PC_WIDTH'(imm_q);

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    src_d    = src_q;
    sub_d    = sub_q;
    cflag_d  = cflag_q;
    halted_d = halted_q;
    lda_d    = 1'b0;
    ldb_d    = 1'b0;
    ldo_d    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end

      // Strobes are decoded here and registered so they are high for exactly
      // the EXECUTE cycle with no combinational path from the ROM.
      S_DECODE: begin
        imm_d   = ir_q[3:0];
        src_d   = 2'b00;
        sub_d   = 1'b0;
        state_d = S_EXECUTE;
        case (op)
          OP_LDAI:  lda_d = 1'b1;
          OP_LDBI:  ldb_d = 1'b1;
          OP_ADD:   begin lda_d = 1'b1; src_d = 2'b01; end
          OP_SUB:   begin lda_d = 1'b1; src_d = 2'b01; sub_d = 1'b1; end
          OP_OUT:   ldo_d = 1'b1;
          OP_MOVBA: begin ldb_d = 1'b1; src_d = 2'b10; end
          default:  ;
        endcase
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_ADD, OP_SUB: cflag_d = alu_carry;
          OP_JMP:         pc_d    = pc_imm;
          OP_JC:          pc_d    = cflag_q ? pc_imm : pc_inc;
          OP_HLT: begin
            pc_d     = pc_q;
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      src_q    <= '0;
      sub_q    <= 1'b0;
      cflag_q  <= 1'b0;
      lda_q    <= 1'b0;
      ldb_q    <= 1'b0;
      ldo_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      src_q    <= src_d;
      sub_q    <= sub_d;
      cflag_q  <= cflag_d;
      lda_q    <= lda_d;
      ldb_q    <= ldb_d;
      ldo_q    <= ldo_d;
      halted_q <= halted_d;
    end
  end

  assign pc      = pc_q;
  assign imm     = imm_q;
  assign src_sel = src_q;
  assign alu_sub = sub_q;
  assign LDA     = lda_q;
  assign LDB     = ldb_q;
  assign LDO     = ldo_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. A combinational ROM model is driven
// from pc; every expected value is hand-derived from the 3-cycle schedule
// (instruction n strobes in cycle 3n+2, cycle 0 = first FETCH after reset).
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] instr;
  logic       alu_carry;
  logic [3:0] pc;
  logic [3:0] imm;
  logic [1:0] src_sel;
  logic       alu_sub;
  logic       LDA, LDB, LDO;
  logic       halted;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step;
`endif

  logic [7:0] rom [16];
  int unsigned tests;
  int unsigned fails;

  assign instr = rom[pc];

  control_sequencer #(.PC_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .alu_carry (alu_carry),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .pc        (pc),
    .imm       (imm),
    .src_sel   (src_sel),
    .alu_sub   (alu_sub),
    .LDA       (LDA),
    .LDB       (LDB),
    .LDO       (LDO),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Holds reset for two cycles and releases it at a falling edge; the
  // caller is then in cycle 0 (first FETCH).
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  logic [2:0] exp_st;
  logic [3:0] exp_pc;

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    alu_carry = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step      = 1'b1;
`endif

    // Program 1: LDAI 3; LDBI 5; ADD; OUT; HLT
    clear_rom();
    rom[0] = 8'h13;
    rom[1] = 8'h25;
    rom[2] = 8'h30;
    rom[3] = 8'h50;
    rom[4] = 8'hF0;

    // Reset asserted in the middle of the first LDAI EXECUTE
    do_reset();
    chk("rst_pc0", {4'h0, pc}, 8'h00);
    chk("rst_strobes0", {5'h0, LDA, LDB, LDO}, 8'h00);
    repeat (2) @(negedge clk);
    chk("pre_rst_lda", {7'h0, LDA}, 8'h01);
    chk("pre_rst_imm", {4'h0, imm}, 8'h03);
    #2 reset = 1'b1;
    #1;
    chk("async_lda", {7'h0, LDA}, 8'h00);
    chk("async_imm", {4'h0, imm}, 8'h00);
    chk("async_pc", {4'h0, pc}, 8'h00);
    @(negedge clk);
    chk("rst_edge_lda", {7'h0, LDA}, 8'h00);
    chk("rst_edge_halted", {7'h0, halted}, 8'h00);
    reset = 1'b0;
    #1;

    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      exp_st = (c == 2 || c == 8) ? 3'b100 :
               (c == 5)           ? 3'b010 :
               (c == 11)          ? 3'b001 : 3'b000;
      exp_pc = (c < 15) ? 4'(c / 3) : 4'd4;
      chk($sformatf("p1_strobes_c%0d", c), {5'h0, LDA, LDB, LDO}, {5'h0, exp_st});
      chk($sformatf("p1_pc_c%0d", c), {4'h0, pc}, {4'h0, exp_pc});
      chk($sformatf("p1_halted_c%0d", c), {7'h0, halted}, (c >= 15) ? 8'h01 : 8'h00);
      if (c == 2) begin
        chk("p1_ldai_imm", {4'h0, imm}, 8'h03);
        chk("p1_ldai_src", {6'h0, src_sel}, 8'h00);
      end
      if (c == 5) chk("p1_ldbi_imm", {4'h0, imm}, 8'h05);
      if (c == 8) begin
        chk("p1_add_src", {6'h0, src_sel}, 8'h01);
        chk("p1_add_sub", {7'h0, alu_sub}, 8'h00);
      end
    end

    // Program 2: SUB; JC A (taken, carry=1) ... A: SUB; B: JC 5 (not taken); C: HLT
    clear_rom();
    rom[0]  = 8'h40;
    rom[1]  = 8'h8A;
    rom[10] = 8'h40;
    rom[11] = 8'h85;
    rom[12] = 8'hF0;
    alu_carry = 1'b1;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      alu_carry = (c < 6);
      exp_pc = (c < 3) ? 4'h0 : (c < 6) ? 4'h1 : (c < 9) ? 4'hA :
               (c < 12) ? 4'hB : 4'hC;
      exp_st = (c == 2 || c == 8) ? 3'b100 : 3'b000;
      chk($sformatf("p2_pc_c%0d", c), {4'h0, pc}, {4'h0, exp_pc});
      chk($sformatf("p2_strobes_c%0d", c), {5'h0, LDA, LDB, LDO}, {5'h0, exp_st});
      if (c == 2 || c == 8) begin
        chk($sformatf("p2_sub_src_c%0d", c), {6'h0, src_sel}, 8'h01);
        chk($sformatf("p2_sub_op_c%0d", c), {7'h0, alu_sub}, 8'h01);
      end
      if (c == 16) chk("p2_halted", {7'h0, halted}, 8'h01);
    end

    // Program 3: illegal 0xC; MOVBA; JMP F; F: NOP -> wrap to 0
    clear_rom();
    rom[0]  = 8'hC0;
    rom[1]  = 8'h60;
    rom[2]  = 8'h7F;
    rom[15] = 8'h00;
    alu_carry = 1'b0;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      exp_pc = (c < 3) ? 4'h0 : (c < 6) ? 4'h1 : (c < 9) ? 4'h2 :
               (c < 12) ? 4'hF : 4'h0;
      exp_st = (c == 5) ? 3'b010 : 3'b000;
      chk($sformatf("p3_pc_c%0d", c), {4'h0, pc}, {4'h0, exp_pc});
      chk($sformatf("p3_strobes_c%0d", c), {5'h0, LDA, LDB, LDO}, {5'h0, exp_st});
      if (c == 5) chk("p3_movba_src", {6'h0, src_sel}, 8'h02);
    end

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: program 1 again, step held low then one pulse
    clear_rom();
    rom[0] = 8'h13;
    rom[1] = 8'h25;
    step = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("ss_idle_pc_c%0d", c), {4'h0, pc}, 8'h00);
      chk($sformatf("ss_idle_strobes_c%0d", c), {5'h0, LDA, LDB, LDO}, 8'h00);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("ss_decode_strobes", {5'h0, LDA, LDB, LDO}, 8'h00);
    @(negedge clk);
    chk("ss_exec_lda", {5'h0, LDA, LDB, LDO}, 8'h04);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("ss_after_pc_c%0d", c), {4'h0, pc}, 8'h01);
      chk($sformatf("ss_after_strobes_c%0d", c), {5'h0, LDA, LDB, LDO}, 8'h00);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Fetch/decode/execute controller for the 4-bit Aeolus datapath. It generates the program counter and drives the register file's load strobes (LDA, LDB, LDO), plus the register-input source select and the ALU operation. It sits between the combinational program ROM and the register file/ALU, and is the sole issuer of register-file write strobes. Each instruction takes exactly three cycles unless the sequencer is halted.

## Interface
Parameters:
- `PC_WIDTH`, default 4: program counter width. The ROM depth is 2^PC_WIDTH.

Ports:
- `clk`  input  1: system clock, rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `instr`  input  8: ROM word at `pc`. [7:4] is the opcode, [3:0] is the immediate.
- `alu_carry`  input  1: ALU carry/borrow out, valid combinationally during EXECUTE.
- `step`  input  1: single-step pulse. Present only when `SEQ_SINGLE_STEP_EN` is defined.
- `pc`  output  PC_WIDTH: ROM address (registered).
- `imm`  output  4: immediate field of the held instruction (registered).
- `src_sel`  output  2: register-input source. 00 = imm, 01 = ALU result, 10 = A register.
- `alu_sub`  output  1: 1 = subtract (A−B), 0 = add (A+B).
- `LDA`, `LDB`, `LDO`  output  1 each: single-cycle register-file load enables.
- `halted`  output  1: high while in HALT.

## Operation
- States: FETCH → DECODE → EXECUTE → FETCH, plus HALT. Encoding is free.
- **FETCH:** `instr` is captured into IR at the end of the cycle.
- **DECODE:** IR is decoded, and `imm`, `src_sel` and `alu_sub` are registered. These three hold their values through EXECUTE.
- **EXECUTE:** exactly one strobe is asserted for this single cycle, per opcode:
  - 0x0 NOP: no strobe.
  - 0x1 LDAI: LDA, src_sel=00.
  - 0x2 LDBI: LDB, src_sel=00.
  - 0x3 ADD: LDA, src_sel=01, alu_sub=0.
  - 0x4 SUB: LDA, src_sel=01, alu_sub=1.
  - 0x5 OUT: LDO. O is wired from A.
  - 0x6 MOVBA: LDB, src_sel=10.
  - 0x7 JMP imm: no strobe.
  - 0x8 JC imm: no strobe.
  - 0xF HLT: no strobe.
  - 0x9–0xE: execute as NOP.
- **Carry flag (internal `cflag`):** updated from `alu_carry` at the end of EXECUTE, for ADD/SUB only. It is unchanged by all other opcodes.
- **PC update:** at the end of EXECUTE, `pc` ← imm (zero-extended) for JMP, or for JC when `cflag`=1. Otherwise `pc` ← pc+1, wrapping from 2^PC_WIDTH−1 to 0.
- **JC flag timing:** JC tests the `cflag` value held before its own EXECUTE edge.
- **HLT:** the sequencer enters HALT after its EXECUTE. `pc` is not incremented, and HALT is left only by `reset`.
- **Idle strobes:** LDA/LDB/LDO are 0 in FETCH, DECODE and HALT.
- **Reset (asynchronous, any state, including mid-EXECUTE):**
  - State → FETCH.
  - `pc`, IR, `imm`, `src_sel`, `alu_sub`, `cflag`, `halted` → 0.
  - LDA/LDB/LDO → 0 immediately, so no strobe fires on the edge that coincides with reset.

## Timing
- **Outputs:** all outputs are registered. There are no combinational paths from `instr` or `alu_carry` to outputs.
- **Throughput:** 3 cycles per instruction. Instruction n's strobe is asserted in cycle 3n+2, counting the first FETCH after reset release as cycle 0.
- **ROM:** `pc` is stable for all three cycles of an instruction, and the ROM must be valid before the end of FETCH.
- **Register-file writes:** the register file captures data on the rising edge that ends EXECUTE, while the strobe is high.
- **Immediate jumps:** `pc` changes on that same edge, and the next FETCH uses the new value.
- **Reset release:** the first FETCH occurs in the cycle after `reset` deasserts.

## Configuration
- **`SEQ_SINGLE_STEP_EN` defined:**
  - The `step` port exists.
  - The sequencer stays in FETCH, with IR not loaded, until it samples `step`=1 at a rising edge. Only then does it capture `instr` and advance to DECODE.
  - `step` is ignored in DECODE, EXECUTE and HALT, so one pulse runs one instruction.
  - Holding `step` high runs at full rate.
- **Undefined:**
  - No `step` port.
  - FETCH always lasts one cycle (free-running).

## Test plan
- **Reset values:** assert reset mid-EXECUTE of an LDAI → outputs drop to 0 asynchronously, with no LDA on the next edge. After release, `pc`=0 and FETCH is the first cycle.
- **Load and output sequence:** ROM LDAI 3; LDBI 5; ADD; OUT; HLT → LDA in cycle 2, LDB in cycle 5, and LDA with src_sel=01, alu_sub=0 in cycle 8. LDO follows in cycle 11, then `halted`=1 with `pc`=4 held.
- **Conditional jump:** SUB with `alu_carry`=1 driven, then JC 0xA → `pc`=0xA after JC. Repeat with `alu_carry`=0 → `pc`=SUB address+2.
- **PC wrap:** NOP at 0xF with `pc` reaching 15 → next `pc`=0.
- **Illegal opcode and MOVBA:** opcode 0xC → no strobe and `pc` increments. MOVBA → LDB with src_sel=10.
- **Single step (`SEQ_SINGLE_STEP_EN`):** hold `step`=0 for 10 cycles → `pc` unchanged and no strobes. One `step` pulse → exactly one instruction executes.
